// File: rtl/mmul_stream.sv
// -----------------------------------------------------------------------------
// mmul_stream
// Streaming matrix-vector multiplier: c[i] = sum_k a[i][k] * b[k] for M rows over
// a runtime length K (1..N). b is read once per step and passed down a skewed
// chain of M rows. Each row fetches its own a operand one stage after b reaches
// it, and accumulates the product modulo 2^ACC_WIDTH.
//
// Ports
//   i_clk, i_rst     clock, synchronous active-high reset
//   i_clr            synchronous clear of FSM, pipeline valids and accumulators
//   i_start          start pulse, honoured in IDLE/DONE only
//   i_len            vector length K (clamped to N), sampled on start
//   i_signed         1 = two's-complement operands, sampled on start
//   i_accumulate     1 = keep accumulators across ops, sampled on start
//   o_busy, o_valid  busy in RUN/DRAIN, valid in DONE
//   o_b_rden         b FIFO read strobe; i_b_empty/i_b from the b FIFO
//   o_a_rden, i_a    per-row a FIFO strobes and data (row i at bits i*DATA_WIDTH)
//   o_c              per-row accumulators (row i at bits i*ACC_WIDTH)
// -----------------------------------------------------------------------------
module mmul_stream #(
   parameter int DATA_WIDTH = 8,
   parameter int N          = 8,
   parameter int M          = 8,
   parameter int ACC_WIDTH  = 2*DATA_WIDTH + $clog2(N)
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic                      i_clr,
   input  logic                      i_start,
   input  logic [$clog2(N+1)-1:0]    i_len,
   input  logic                      i_signed,
   input  logic                      i_accumulate,
   output logic                      o_busy,
   output logic                      o_valid,
   output logic                      o_b_rden,
   input  logic                      i_b_empty,
   input  logic [DATA_WIDTH-1:0]     i_b,
   output logic [M-1:0]              o_a_rden,
   input  logic [M*DATA_WIDTH-1:0]   i_a,
   output logic [M*ACC_WIDTH-1:0]    o_c
);

   localparam int LW  = $clog2(N+1);
   localparam int DCW = $clog2(M+2);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]            r_state;
   logic [LW-1:0]         r_rem;      // b reads still to issue
   logic [DCW-1:0]        r_dcnt;     // cycles spent in DRAIN
   logic                  r_signed;
   logic                  r_v0;       // stage-0 valid (registered b read)
   logic [M-1:0]          r_v;        // per-row registered valid
   logic [DATA_WIDTH-1:0] r_b   [M];
   logic [ACC_WIDTH-1:0]  r_acc [M];

   logic                  w_start;
   logic [LW-1:0]         w_len;
   logic                  w_b_rden;
   logic [M-1:0]          w_vin;
   logic [DATA_WIDTH-1:0] w_bin  [M];
   logic [ACC_WIDTH-1:0]  w_prod [M];

   function automatic logic [ACC_WIDTH-1:0] f_ext(input logic [DATA_WIDTH-1:0] x,
                                                   input logic s);
      return {{(ACC_WIDTH-DATA_WIDTH){s & x[DATA_WIDTH-1]}}, x};
   endfunction

   assign w_start  = i_start && !i_clr && (r_state == S_IDLE || r_state == S_DONE);
   assign w_len    = (i_len > LW'(N)) ? LW'(N) : i_len;
   assign w_b_rden = (r_state == S_RUN) && !i_b_empty;

   assign o_b_rden = w_b_rden;
   assign o_busy   = (r_state == S_RUN) || (r_state == S_DRAIN);
   assign o_valid  = (r_state == S_DONE);
   assign o_a_rden = w_vin;

   // Row chain: row 0 takes the FIFO output, row g takes row g-1's registers.
   for (genvar g = 0; g < M; g++) begin : g_row
      if (g == 0) begin : g_first
         assign w_vin[g] = r_v0;
         assign w_bin[g] = i_b;
      end else begin : g_next
         assign w_vin[g] = r_v[g-1];
         assign w_bin[g] = r_b[g-1];
      end
      // a arrives one cycle after o_a_rden, aligned with r_b/r_v of this row.
      assign w_prod[g] = f_ext(i_a[g*DATA_WIDTH +: DATA_WIDTH], r_signed)
                       * f_ext(r_b[g], r_signed);
      assign o_c[g*ACC_WIDTH +: ACC_WIDTH] = r_acc[g];
   end

   // Control FSM
   always_ff @(posedge i_clk) begin
      if (i_rst || i_clr) begin
         r_state  <= S_IDLE;
         r_rem    <= '0;
         r_dcnt   <= '0;
         r_signed <= 1'b0;
      end else begin
         if (r_state != S_DRAIN) r_dcnt <= '0;
         case (r_state)
            S_IDLE, S_DONE: begin
               if (w_start) begin
                  r_signed <= i_signed;
                  r_rem    <= w_len;
                  r_state  <= (w_len == '0) ? S_DRAIN : S_RUN;
               end
            end
            S_RUN: begin
               // Empty FIFO: no read, counter holds (bubble).
               if (w_b_rden) begin
                  r_rem <= r_rem - LW'(1);
                  if (r_rem == LW'(1)) r_state <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               // M+1 cycles let the last b reach row M-1 and its MAC land.
               r_dcnt <= r_dcnt + DCW'(1);
               if (r_dcnt == DCW'(M)) r_state <= S_DONE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Datapath: b/valid chain and per-row accumulators
   always_ff @(posedge i_clk) begin
      if (i_rst || i_clr) begin
         r_v0 <= 1'b0;
         r_v  <= '0;
         for (int i = 0; i < M; i++) begin
            r_b[i]   <= '0;
            r_acc[i] <= '0;
         end
      end else begin
         r_v0 <= w_b_rden;
         r_v  <= w_vin;
         for (int i = 0; i < M; i++) begin
            if (w_vin[i]) r_b[i] <= w_bin[i];
            if (w_start && !i_accumulate) r_acc[i] <= '0;
            else if (r_v[i])              r_acc[i] <= r_acc[i] + w_prod[i];
         end
      end
   end

endmodule

// File: doc/mmul_stream.md
# mmul_stream

Parametrised successor to the 8x8 systolic matrix-vector unit. It computes c[i] = Σ a[i][k]·b[k] for M rows over a runtime length K (1..N) and streams b through a skewed row chain. Additions over the previous generation: a start/busy/done handshake, stall on an empty b FIFO, signed/unsigned mode, a configurable accumulator width, and an accumulate-across-tiles mode. It sits between the operand FIFOs (one b FIFO, M a FIFOs, all with 1-cycle read latency) and the result consumer.

## Interface
- DATA_WIDTH, 8: operand width.
- N, 8: maximum vector length K.
- M, 8: row count (chain depth).
- ACC_WIDTH, 2*DATA_WIDTH+$clog2(N): accumulator and result width. Arithmetic is modulo 2^ACC_WIDTH.
- i_clk  in  1  clock; all logic on rising edge.
- i_rst  in  1  reset, synchronous, active-high.
- i_clr  in  1  synchronous clear: accumulators, pipeline valids and FSM return to reset state.
- i_start  in  1  start pulse; honoured only in IDLE or DONE.
- i_len  in  $clog2(N+1)  K, sampled on start. Values above N are treated as N.
- i_signed  in  1  sampled on start; 1 = two's-complement operands.
- i_accumulate  in  1  sampled on start; 1 = keep accumulators, 0 = zero them.
- o_busy  out  1  high in RUN/DRAIN.
- o_valid  out  1  high in DONE; o_c is final.
- o_b_rden  out  1  b FIFO read strobe.
- i_b_empty  in  1  b FIFO empty.
- i_b  in  DATA_WIDTH  b data, valid the cycle after o_b_rden.
- o_a_rden  out  [M]  per-row a FIFO read strobe.
- i_a  in  [M][DATA_WIDTH]  per-row a data, valid the cycle after o_a_rden[i].
- o_c  out  [M][ACC_WIDTH]  accumulator contents.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE. Reset and i_clr go to IDLE.
- IDLE/DONE + i_start: latch len/signed/accumulate, load the remaining-read counter with len, zero accumulators unless accumulate=1. Next state is RUN, or DRAIN if len=0.
- RUN: o_b_rden = !i_b_empty. Each read decrements the counter. When the final read issues, the next state is DRAIN. An empty FIFO inserts a bubble: the counter holds and no read issues.
- Stage-0 valid = registered o_b_rden; stage-0 data = i_b.
- Row i, when its input valid is high:
  - asserts o_a_rden[i] combinationally;
  - registers b and valid, and forwards both to row i+1;
  - on the following cycle, if the registered valid is set, acc[i] += ext(a)·ext(b_reg), where ext is the sign- or zero-extension to ACC_WIDTH chosen by the latched mode.
- Bubbles propagate through the chain; no MAC occurs on an invalid slot.
- DRAIN: counts M+1 cycles, then moves to DONE.
- DONE: o_valid=1. It holds until i_start (which starts a new op) or i_clr.
- i_start in RUN/DRAIN is ignored.
- i_clr overrides i_start on the same cycle. i_rst overrides everything.
- o_a_rden to a row is never issued without a matching prior o_b_rden.

## Timing
- Reset values: o_busy=0, o_valid=0, o_b_rden=0, all o_a_rden=0, all o_c=0. All pipeline valids are 0 and the state is IDLE.
- Cycle numbering with no stalls: start sampled at the end of cycle 0.
  - o_b_rden is high in cycles 1..len.
  - Stage-0 valid is high in cycles 2..len+1.
  - o_a_rden[i] is high in cycles 2+i..len+1+i.
  - acc[i] is updated at the end of cycles 3+i..len+2+i.
  - DRAIN occupies cycles len+1..len+M+1; o_valid rises in cycle len+M+2.
- Each b-empty stall cycle delays all subsequent events by one cycle.
- len=0: no reads; o_valid in cycle M+2; o_c equals the previous values (accumulate=1) or 0.
- o_c changes during RUN/DRAIN and is meaningful only while o_valid=1.
- Back-to-back ops: i_start in the first DONE cycle starts the next op. o_valid drops the following cycle.
- Reset or i_clr mid-operation: all outputs reach reset values the next cycle. In-flight data is discarded and no further rden is issued.

## Test plan
- M=N=4, unsigned, len=4, a = identity rows, b = {1,2,3,4}: c = {1,2,3,4}; o_valid in cycle 10; o_a_rden[3] high in cycles 5..8.
- Signed, DATA_WIDTH=8, len=2, a[0] = {-128,-128}, b = {-128,127}: c[0] = 16384-16256 = 128. Same bits in unsigned mode: c[0] = 128·128 + 128·127 = 32640.
- i_b_empty high in cycles 2..3 during len=4: o_b_rden low in those cycles; o_valid in cycle 12; results identical to the unstalled run.
- Accumulate: op1 gives c[0]=10; op2 with accumulate=1 adds 5, so c[0]=15. Op3 with accumulate=0 adds 5, so c[0]=5.
- len=0, and i_len=N+3: no reads with o_valid in cycle M+2; and exactly N reads respectively.
- i_clr in cycle 3 of a run: all outputs reach reset values in cycle 4; i_start in cycle 3 ignored; a subsequent fresh op is correct.
